raster_scan_gen: RTL and testbench

Runtime-programmable 2-D raster coordinate generator for the edge-detection datapath. It walks a frame of (xmax_i+1) × (ymax_i+1) pixels in row-major or column-major order and emits one coordinate per beat over a valid/ready handshake. Each beat carries x, y, a linear pixel address and first/last/border flags. It drives the pixel fetch and window logic between the Avalon master and the 3×3 filter core, and replaces fixed-size compile-time scan counters.

---
 rtl/raster_scan_gen.sv | 145 ++++++++++++++
 tb/tb_raster_scan_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/raster_scan_gen.sv
// rtl/raster_scan_gen.sv - runtime-programmable 2-D raster coordinate generator
module raster_scan_gen #(
  parameter int X_W    = 10,
  parameter int Y_W    = 10,
  parameter int ADDR_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [X_W-1:0]    xmax_i,
  input  logic [Y_W-1:0]    ymax_i,
  input  logic              col_major_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [X_W-1:0]    x_o,
  output logic [Y_W-1:0]    y_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              first_o,
  output logic              last_o,
  output logic              border_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d, xmax_q;
  logic [Y_W-1:0]      y_q, y_d, ymax_q;
  logic [ADDR_W-1:0]   addr_q, addr_d, stride_q;
  logic                col_q;
  logic                done_q, done_d;
  logic                load;
  logic                accept;
  logic                x_at_max, y_at_max;

  assign x_at_max = (x_q == xmax_q);
  assign y_at_max = (y_q == ymax_q);
  assign valid_o  = (state_q == RUN);
  assign busy_o   = (state_q == RUN);
  assign accept   = valid_o && ready_i;

  // Flags are derived from the current beat and masked when no beat is offered.
  assign first_o  = valid_o && (x_q == '0) && (y_q == '0);
  assign last_o   = valid_o && x_at_max && y_at_max;
  assign border_o = valid_o && ((x_q == '0) || x_at_max || (y_q == '0) || y_at_max);

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign addr_o = addr_q;
  assign done_o = done_q;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and next-coordinate logic; the address only ever uses adders.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d = RUN;
          load    = 1'b1;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end else if (accept) begin
          if (x_at_max && y_at_max) begin
            state_d = IDLE;
            done_d  = 1'b1;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
          end else if (!col_q) begin
            addr_d = addr_q + ADDR_W'(1);
            if (!x_at_max) begin
              x_d = x_q + X_W'(1);
            end else begin
              x_d = '0;
              y_d = y_q + Y_W'(1);
            end
          end else begin
            if (!y_at_max) begin
              y_d    = y_q + Y_W'(1);
              addr_d = addr_q + stride_q;
            end else begin
              y_d    = '0;
              x_d    = x_q + X_W'(1);
              addr_d = ADDR_W'(x_q) + ADDR_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Coordinate, address and done-pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
      done_q <= done_d;
    end
  end

  // Frame bounds, scan order and column-major stride captured on an accepted start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      xmax_q   <= '0;
      ymax_q   <= '0;
      col_q    <= 1'b0;
      stride_q <= '0;
    end else if (load) begin
      xmax_q   <= xmax_i;
      ymax_q   <= ymax_i;
      col_q    <= col_major_i;
      stride_q <= ADDR_W'(xmax_i) + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_raster_scan_gen.sv
// tb/tb_raster_scan_gen.sv - randomized self-checking bench for raster_scan_gen
module tb_raster_scan_gen;

  localparam int X_W = 10;
  localparam int Y_W = 10;
  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [X_W-1:0]    xmax = '0;
  logic [Y_W-1:0]    ymax = '0;
  logic              col = 1'b0;
  logic              ready = 1'b0;
  logic              valid, first, last, border, busy, done;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr;

  int total = 0;
  int passed = 0;

  raster_scan_gen #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .xmax_i(xmax), .ymax_i(ymax), .col_major_i(col), .ready_i(ready),
    .valid_o(valid), .x_o(x), .y_o(y), .addr_o(addr),
    .first_o(first), .last_o(last), .border_o(border),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_flags"}, {first, last, border}, 0);
  endtask

  // stop_mode: 0 run to completion, 1 abort at beat stop_idx, 2 async reset at beat stop_idx
  task automatic run_frame(input int xm, input int ym, input int cm, input int pct,
                           input int stop_mode, input int stop_idx);
    int ex[$];
    int ey[$];
    int n, idx, budget, bx, by;
    if (cm == 0) begin
      for (int j = 0; j <= ym; j++) for (int i = 0; i <= xm; i++) begin ex.push_back(i); ey.push_back(j); end
    end else begin
      for (int i = 0; i <= xm; i++) for (int j = 0; j <= ym; j++) begin ex.push_back(i); ey.push_back(j); end
    end
    n = ex.size();
    @(negedge clk);
    xmax = X_W'(xm); ymax = Y_W'(ym); col = cm[0]; start = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    xmax = X_W'($urandom); ymax = Y_W'($urandom); col = 1'($urandom);
    idx = 0;
    budget = 0;
    while (idx < n && budget < 4000) begin
      bx = ex[idx];
      by = ey[idx];
      check("valid", valid, 1);
      check("busy", busy, 1);
      check("done_in_run", done, 0);
      check("x", x, bx);
      check("y", y, by);
      check("addr", addr, (by * (xm + 1) + bx) % (1 << ADDR_W));
      check("first", first, (bx == 0 && by == 0));
      check("last", last, (bx == xm && by == ym));
      check("border", border, (bx == 0 || bx == xm || by == 0 || by == ym));
      if (stop_mode == 1 && idx == stop_idx) begin
        abort = 1'b1; ready = 1'b1; start = 1'b0;
        @(negedge clk);
        abort = 1'b0; ready = 1'b0;
        check_idle("abort");
        check("abort_done", done, 0);
        @(negedge clk);
        check("abort_done2", done, 0);
        return;
      end
      if (stop_mode == 2 && idx == stop_idx) begin
        ready = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        #1;
        check_idle("areset");
        check("areset_done", done, 0);
        @(negedge clk);
        check("areset_hold_valid", valid, 0);
        check("areset_hold_busy", busy, 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("post_reset");
        check("post_reset_done", done, 0);
        return;
      end
      ready = ($urandom_range(0, 99) < pct);
      start = (idx < n - 1) ? 1'($urandom) : 1'b0;
      @(negedge clk);
      if (ready) idx++;
      budget++;
    end
    check("frame_timeout", budget < 4000, 1);
    ready = 1'b0;
    start = 1'b0;
    check("done_pulse", done, 1);
    check_idle("after_last");
    @(negedge clk);
    check("done_low", done, 0);
  endtask

  initial begin
    start = 1'b1;
    #12;
    check_idle("reset");
    check("reset_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("reset_release");

    run_frame(2, 1, 0, 100, 0, 0);
    run_frame(2, 1, 1, 100, 0, 0);
    run_frame(3, 3, 0, 50, 0, 0);
    run_frame(3, 3, 1, 40, 0, 0);
    run_frame(3, 3, 0, 100, 1, 3);
    run_frame(3, 3, 0, 100, 0, 0);

    // single-pixel frames back to back with start held high
    @(negedge clk);
    xmax = '0; ymax = '0; col = 1'b0; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    check("b2b_v1", valid, 1);
    check("b2b_flags1", {first, last, border}, 3'b111);
    @(negedge clk);
    check("b2b_gap_valid", valid, 0);
    check("b2b_gap_done", done, 1);
    @(negedge clk);
    check("b2b_v2", valid, 1);
    check("b2b_flags2", {first, last, border}, 3'b111);
    start = 1'b0;
    @(negedge clk);
    check("b2b_done2", done, 1);
    check("b2b_v2_gone", valid, 0);
    ready = 1'b0;
    @(negedge clk);
    check("b2b_done_low", done, 0);

    for (int k = 0; k < 10; k++)
      run_frame($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 1),
                $urandom_range(35, 100), 0, 0);

    run_frame(3, 3, 0, 100, 2, 6);
    run_frame(1, 2, 1, 70, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
